// File: rtl/async_fifo_8_wptr_ctrl_pkg.sv
// Shared constants, pointer type and Gray decode helper
// for the 8-entry async FIFO write-side pointer logic.
package async_fifo_8_pkg;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;
  localparam int PTR_W  = 4;

  typedef logic [PTR_W-1:0] ptr_t;

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[PTR_W-1] = g[PTR_W-1];
    for (int i = PTR_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/async_fifo_8_wptr_ctrl_if.sv
// Write-port bundle: upstream request, RAM strobe/address,
// Gray pointers to/from read domain, full/level/overflow status.
interface async_fifo_8_wptr_ctrl_if;
  import async_fifo_8_pkg::*;

  logic              wvalid;
  logic              wready;
  logic [ADDR_W-1:0] waddr;
  logic              wen;
  ptr_t              wptr_gray;
  ptr_t              rptr_gray_async;
  logic              wfull;
  logic [PTR_W-1:0]  wlevel;
  logic              woverflow;

  modport master (
    output wvalid,
    output rptr_gray_async,
    input  wready,
    input  waddr,
    input  wen,
    input  wptr_gray,
    input  wfull,
    input  wlevel,
    input  woverflow
  );

  modport slave (
    input  wvalid,
    input  rptr_gray_async,
    output wready,
    output waddr,
    output wen,
    output wptr_gray,
    output wfull,
    output wlevel,
    output woverflow
  );

endinterface

// File: rtl/async_fifo_8_wptr_ctrl_gray.sv
// 4-bit binary to Gray encoder (b ^ (b >> 1)).
// Ports: bin_i binary in, gray_o Gray out.
module graycode_encoder_16
  import async_fifo_8_pkg::*;
(
  input  ptr_t bin_i,
  output ptr_t gray_o
);

  assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/async_fifo_8_wptr_ctrl.sv
// Write-domain pointer controller for the 8-entry async FIFO.
// Ports: clk, rst (sync, active-high), wif (slave write bundle).
module async_fifo_8_wptr_ctrl
  import async_fifo_8_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int OVF_STICKY  = 1
) (
  input logic                     clk,
  input logic                     rst,
  async_fifo_8_wptr_ctrl_if.slave wif
);

  ptr_t wbin_q, wbin_d;
  ptr_t wptr_gray_q, wptr_gray_d;
  ptr_t wgray_nxt;
  ptr_t rsync;
  logic wfull_q, wfull_d;
  logic woverflow_q, woverflow_d;
  logic acc, ovf;

  logic [SYNC_STAGES-1:0][PTR_W-1:0] rq_q, rq_d;

  graycode_encoder_16 u_gray (
    .bin_i  (wbin_d),
    .gray_o (wgray_nxt)
  );

  // A request seen while rst is high is never written.
  always_comb begin
    acc         = wif.wvalid & ~wfull_q & ~rst;
    ovf         = wif.wvalid & wfull_q;
    wbin_d      = wbin_q + {{(PTR_W-1){1'b0}}, acc};
    wptr_gray_d = wgray_nxt;
    rsync       = rq_q[SYNC_STAGES-1];
    // Full: next write pointer is one lap ahead of the
    // synchronised read pointer (top two Gray bits flipped).
    wfull_d     = (wgray_nxt == {~rsync[3:2], rsync[1:0]});
    if (OVF_STICKY != 0) begin
      woverflow_d = woverflow_q | ovf;
    end else begin
      woverflow_d = ovf;
    end
  end

  // Plain flop chain, nothing between stages.
  always_comb begin
    rq_d    = rq_q;
    rq_d[0] = wif.rptr_gray_async;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      rq_d[k] = rq_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wbin_q      <= '0;
      wptr_gray_q <= '0;
      rq_q        <= '0;
      wfull_q     <= 1'b0;
      woverflow_q <= 1'b0;
    end else begin
      wbin_q      <= wbin_d;
      wptr_gray_q <= wptr_gray_d;
      rq_q        <= rq_d;
      wfull_q     <= wfull_d;
      woverflow_q <= woverflow_d;
    end
  end

  assign wif.wready    = ~wfull_q;
  assign wif.wen       = acc;
  assign wif.waddr     = wbin_q[ADDR_W-1:0];
  assign wif.wptr_gray = wptr_gray_q;
  assign wif.wfull     = wfull_q;
  assign wif.wlevel    = wbin_q - gray2bin(rsync);
  assign wif.woverflow = woverflow_q;

endmodule

// File: tb/tb_async_fifo_8_wptr_ctrl.sv
// Scoreboard bench for async_fifo_8_wptr_ctrl: directed
// fill/overflow/drain/wrap/reset plus random traffic.
module tb_async_fifo_8_wptr_ctrl;
  import async_fifo_8_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  async_fifo_8_wptr_ctrl_if wif();

  async_fifo_8_wptr_ctrl #(
    .SYNC_STAGES (2),
    .OVF_STICKY  (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .wif (wif.slave)
  );

  typedef struct {
    logic       wready;
    logic       wen;
    logic [2:0] waddr;
    logic [3:0] wptr_gray;
    logic       wfull;
    logic [3:0] wlevel;
    logic       woverflow;
  } exp_t;

  exp_t exp_q[$];
  int   addr_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: write count mod 16, read index seen after
  // a 2-cycle synchroniser delay, full/overflow status.
  int   m_wr;
  int   m_pipe[2];
  bit   m_full;
  bit   m_ovf;
  int   rd;
  bit   wrap_seen = 0;

  function automatic logic [3:0] gray(input int b);
    logic [3:0] x;
    x = b[3:0];
    return x ^ (x >> 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wr = 0; m_full = 0; m_ovf = 0;
    m_pipe[0] = 0; m_pipe[1] = 0;
    rd = 0;
  endtask

  task automatic step(input logic v, input int rb, input logic r);
    exp_t e;
    int   nw;
    rst = r;
    wif.wvalid = v;
    wif.rptr_gray_async = gray(rb);
    e.wready    = !m_full;
    e.wen       = v && !m_full && !r;
    e.waddr     = 3'(m_wr % 8);
    e.wptr_gray = gray(m_wr);
    e.wfull     = m_full;
    e.wlevel    = 4'((m_wr - m_pipe[1]) & 15);
    e.woverflow = m_ovf;
    exp_q.push_back(e);
    if (e.wen) addr_q.push_back(m_wr % 8);
    if (r) begin
      model_reset();
    end else begin
      nw = (m_wr + (e.wen ? 1 : 0)) % 16;
      m_ovf  = m_ovf | (v && m_full);
      m_full = (((nw - m_pipe[1]) & 15) == 8);
      m_pipe[1] = m_pipe[0];
      m_pipe[0] = rb;
      m_wr = nw;
    end
    @(posedge clk);
    #1;
  endtask

  logic [3:0] prev_g;
  bit         prev_ok = 0;

  always @(negedge clk) begin
    exp_t e;
    int   a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("wready",    int'(wif.wready),    int'(e.wready));
      chk("wen",       int'(wif.wen),       int'(e.wen));
      chk("wptr_gray", int'(wif.wptr_gray), int'(e.wptr_gray));
      chk("wfull",     int'(wif.wfull),     int'(e.wfull));
      chk("wlevel",    int'(wif.wlevel),    int'(e.wlevel));
      chk("woverflow", int'(wif.woverflow), int'(e.woverflow));
      if (e.wen) chk("waddr_on_wen", int'(wif.waddr), int'(e.waddr));
    end
    if (wif.wen === 1'b1) begin
      if (addr_q.size() == 0) begin
        chk("unexpected_wen", 1, 0);
      end else begin
        a = addr_q.pop_front();
        chk("write_addr", int'(wif.waddr), a);
      end
    end
    if (rst !== 1'b0) begin
      prev_ok = 0;
    end else begin
      if (prev_ok) begin
        chk("gray_one_bit", $countones(prev_g ^ wif.wptr_gray) <= 1 ? 1 : 0, 1);
        if (prev_g == 4'b1000 && wif.wptr_gray == 4'b0000) wrap_seen = 1;
      end
      prev_g  = wif.wptr_gray;
      prev_ok = 1;
    end
  end

  int hist[$];
  int rb;

  initial begin
    rst = 1'b1;
    wif.wvalid = 1'b0;
    wif.rptr_gray_async = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Reset held, reader idle
    step(0, 0, 1);
    step(0, 0, 1);

    // Fill 8, then overflow attempt, then idle (sticky ovf)
    repeat (8) step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);

    // Drain release to read index 3, then a write
    repeat (4) step(0, 3, 0);
    step(1, 3, 0);
    step(0, 3, 0);

    // Wrap with reader tracking writer delayed 4 cycles
    step(0, 0, 1);
    hist.delete();
    repeat (4) hist.push_back(0);
    repeat (40) begin
      rb = hist[hist.size()-4];
      step(1, rb, 0);
      hist.push_back(m_wr);
    end
    repeat (6) begin
      rb = hist[hist.size()-4];
      step(0, rb, 0);
      hist.push_back(m_wr);
    end
    chk("gray_wrap_1000_to_0000", int'(wrap_seen), 1);

    // Reset mid-fill with wvalid held high
    step(0, 0, 1);
    repeat (5) step(1, 0, 0);
    step(1, 0, 1);
    step(1, 0, 1);
    step(1, 0, 0);
    step(0, 0, 0);

    // Random traffic with a legal reader
    step(0, 0, 1);
    repeat (400) begin
      if ($urandom_range(0, 149) == 0) begin
        step(1'($urandom_range(0, 1)), 0, 1);
      end else begin
        if (((m_wr - rd) & 15) != 0 && $urandom_range(0, 2) != 0)
          rd = (rd + 1) % 16;
        step(($urandom_range(0, 3) != 0), rd, 0);
      end
    end

    step(0, rd, 0);
    @(negedge clk);
    #1;
    chk("pending_writes", addr_q.size(), 0);
    chk("pending_status", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
